binary2bcd_seq: RTL and testbench

Parametrised, iterative double-dabble converter: one shift-and-adjust step per clock turns a WIDTH-bit unsigned binary value into DIGITS BCD digits. It replaces the fixed 8-bit combinational converter wherever wide operands or timing closure make a single-cycle tree impractical. It sits between a binary producer and BCD consumers such as display drivers or ASCII formatters. Both sides use valid/ready handshakes, and the block adds a sticky overflow flag for values that do not fit in DIGITS digits.

---
 rtl/binary2bcd_seq.sv | 133 +++++++++++++
 tb/tb_binary2bcd_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/binary2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter: one adjust-and-shift step per clock,
// valid/ready handshakes on both sides, sticky overflow for operands >= 10^DIGITS.
module binary2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_binary,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   packed_bcd,
    output logic [8*DIGITS-1:0]   unpacked_bcd,
    output logic                  overflow,
    output logic                  busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     bin_q, bin_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic                 sticky_q, sticky_d;
    logic [BCD_W-1:0]     packed_q, packed_d;
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q, out_valid_d;

    logic [BCD_W-1:0]     bcd_adj;
    logic [BCD_W+WIDTH:0] shifted;
    logic                 last_iter;

    // Each digit is at most 9 before adjustment, so +3 stays within 4 bits: no inter-digit carry.
    always_comb begin
        for (int k = 0; k < DIGITS; k++) begin
            bcd_adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3
                                                           : bcd_q[4*k +: 4];
        end
    end

    // Top bit is the one leaving the highest digit; it feeds the sticky overflow flag.
    assign shifted   = {bcd_adj, bin_q, 1'b0};
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // NOTE: every _d gets its hold value first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        sticky_d    = sticky_q;
        packed_d    = packed_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d    = in_binary;
                    bcd_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                bin_d    = shifted[WIDTH-1:0];
                bcd_d    = shifted[BCD_W+WIDTH-1:WIDTH];
                sticky_d = sticky_q | shifted[BCD_W+WIDTH];
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    packed_d    = bcd_d;
                    ovf_d       = sticky_d;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            sticky_q    <= 1'b0;
            packed_q    <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            sticky_q    <= sticky_d;
            packed_q    <= packed_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        unpacked_bcd = '0;
        for (int k = 0; k < DIGITS; k++) begin
            unpacked_bcd[8*k +: 8] = {4'd0, packed_q[4*k +: 4]};
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out_valid  = out_valid_q;
    assign packed_bcd = packed_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_binary2bcd_seq.sv
// Self-checking bench: three converter configurations checked against an arithmetic
// decimal-digit model, with directed corner cases and randomized operands.
module tb_binary2bcd_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        in_ready;
        logic        out_valid;
        logic        overflow;
        logic        busy;
        logic [63:0] pk;
        logic [63:0] up;
    } obs_t;

    // Instance A: WIDTH=8, DIGITS=3
    logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_ovf, a_busy;
    logic [7:0]  a_bin = '0;
    logic [11:0] a_pk;
    logic [23:0] a_up;
    // Instance B: WIDTH=8, DIGITS=2
    logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_ovf, b_busy;
    logic [7:0]  b_bin = '0;
    logic [7:0]  b_pk;
    logic [15:0] b_up;
    // Instance C: WIDTH=16, DIGITS=5
    logic        c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0, c_ovf, c_busy;
    logic [15:0] c_bin = '0;
    logic [19:0] c_pk;
    logic [39:0] c_up;

    binary2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_binary(a_bin), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .packed_bcd(a_pk), .unpacked_bcd(a_up), .overflow(a_ovf), .busy(a_busy));

    binary2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_binary(b_bin), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .packed_bcd(b_pk), .unpacked_bcd(b_up), .overflow(b_ovf), .busy(b_busy));

    binary2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_binary(c_bin), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .packed_bcd(c_pk), .unpacked_bcd(c_up), .overflow(c_ovf), .busy(c_busy));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decimal digits by plain division; overflow when the value needs more than `digits` digits.
    function automatic void model(input longint v, input int digits,
                                  output logic [63:0] p, output logic [63:0] u, output logic ovf);
        longint t;
        longint lim;
        t   = v;
        lim = 1;
        p   = '0;
        u   = '0;
        for (int k = 0; k < digits; k++) begin
            p   = p | (64'(t % 10) << (4 * k));
            u   = u | (64'(t % 10) << (8 * k));
            t   = t / 10;
            lim = lim * 10;
        end
        ovf = (v >= lim);
    endfunction

    task automatic drive(input int which, input logic v, input longint bin, input logic rdy);
        case (which)
            0: begin a_in_valid = v; a_bin = bin[7:0];  a_out_ready = rdy; end
            1: begin b_in_valid = v; b_bin = bin[7:0];  b_out_ready = rdy; end
            default: begin c_in_valid = v; c_bin = bin[15:0]; c_out_ready = rdy; end
        endcase
    endtask

    function automatic obs_t peek(input int which);
        obs_t o;
        case (which)
            0: begin
                o.in_ready = a_in_ready; o.out_valid = a_out_valid; o.overflow = a_ovf;
                o.busy = a_busy; o.pk = 64'(a_pk); o.up = 64'(a_up);
            end
            1: begin
                o.in_ready = b_in_ready; o.out_valid = b_out_valid; o.overflow = b_ovf;
                o.busy = b_busy; o.pk = 64'(b_pk); o.up = 64'(b_up);
            end
            default: begin
                o.in_ready = c_in_ready; o.out_valid = c_out_valid; o.overflow = c_ovf;
                o.busy = c_busy; o.pk = 64'(c_pk); o.up = 64'(c_up);
            end
        endcase
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for out_valid after the accept edge; returns cycles counted.
    task automatic wait_valid(input int which, input int bound, output int cyc, output obs_t o);
        cyc = 0;
        o   = peek(which);
        while (!o.out_valid && cyc < bound) begin
            tick();
            cyc++;
            o = peek(which);
        end
    endtask

    task automatic run_op(input int which, input longint v, input int width, input int digits,
                          input string tag);
        obs_t        o;
        int          cyc;
        logic [63:0] ep, eu;
        logic        eo;
        model(v, digits, ep, eu, eo);
        o = peek(which);
        check({tag, ".ready"}, 64'(o.in_ready), 64'(1));
        drive(which, 1'b1, v, 1'b0);
        tick();
        drive(which, 1'b0, 0, 1'b0);
        o = peek(which);
        check({tag, ".busy"}, 64'(o.busy), 64'(1));
        wait_valid(which, width + 4, cyc, o);
        check({tag, ".latency"}, 64'(cyc), 64'(width));
        check({tag, ".packed"}, o.pk, ep);
        check({tag, ".unpacked"}, o.up, eu);
        check({tag, ".overflow"}, 64'(o.overflow), 64'(eo));
        drive(which, 1'b0, 0, 1'b1);
        tick();
        drive(which, 1'b0, 0, 1'b0);
        o = peek(which);
        check({tag, ".valid_clr"}, 64'(o.out_valid), 64'(0));
        check({tag, ".idle"}, 64'(o.in_ready), 64'(1));
    endtask

    initial begin
        obs_t        o;
        int          cyc;
        logic [63:0] ep, eu, hold_pk;
        logic        eo;
        int          nxt, done_cnt, ready_cycles, cycles;
        int          exp_q[$];
        logic        accept;

        // Reset state of all three instances
        tick();
        tick();
        for (int w = 0; w < 3; w++) begin
            o = peek(w);
            check("reset.in_ready", 64'(o.in_ready), 64'(1));
            check("reset.out_valid", 64'(o.out_valid), 64'(0));
            check("reset.packed", o.pk, 64'(0));
            check("reset.overflow", 64'(o.overflow), 64'(0));
            check("reset.busy", 64'(o.busy), 64'(0));
        end
        rst_n = 1'b1;
        tick();

        // Directed cases
        run_op(0, 255, 8, 3, "a255");
        check("a255.literal", 64'(a_pk), 64'h255);
        check("a255.unp_literal", 64'(a_up), 64'h020505);
        run_op(1, 99, 8, 2, "b99");
        run_op(1, 100, 8, 2, "b100");
        check("b100.ovf_literal", 64'(b_ovf), 64'(1));
        run_op(1, 255, 8, 2, "b255");
        run_op(1, 0, 8, 2, "b0");
        run_op(2, 65535, 16, 5, "c65535");
        check("c65535.literal", 64'(c_pk), 64'h65535);
        run_op(0, 0, 8, 3, "a0");

        // Backpressure: result held 5 cycles while a new operand waits
        model(123, 3, ep, eu, eo);
        drive(0, 1'b1, 123, 1'b0);
        tick();
        drive(0, 1'b0, 0, 1'b0);
        wait_valid(0, 12, cyc, o);
        check("bp.latency", 64'(cyc), 64'(8));
        check("bp.packed", o.pk, ep);
        hold_pk = o.pk;
        drive(0, 1'b1, 42, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            o = peek(0);
            check("bp.hold_valid", 64'(o.out_valid), 64'(1));
            check("bp.hold_ready", 64'(o.in_ready), 64'(0));
            check("bp.hold_packed", o.pk, hold_pk);
        end
        drive(0, 1'b1, 42, 1'b1);
        tick();
        drive(0, 1'b1, 42, 1'b0);
        o = peek(0);
        check("bp.after_hs_valid", 64'(o.out_valid), 64'(0));
        check("bp.after_hs_ready", 64'(o.in_ready), 64'(1));
        check("bp.not_accepted_yet", 64'(o.busy), 64'(0));
        tick();
        drive(0, 1'b0, 0, 1'b0);
        o = peek(0);
        check("bp42.busy", 64'(o.busy), 64'(1));
        wait_valid(0, 12, cyc, o);
        check("bp42.latency", 64'(cyc), 64'(8));
        check("bp42.packed", o.pk, 64'h042);
        drive(0, 1'b0, 0, 1'b1);
        tick();
        drive(0, 1'b0, 0, 1'b0);

        // Reset during the third SHIFT iteration
        drive(0, 1'b1, 200, 1'b0);
        tick();
        drive(0, 1'b0, 0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        o = peek(0);
        check("rst_mid.in_ready", 64'(o.in_ready), 64'(1));
        check("rst_mid.out_valid", 64'(o.out_valid), 64'(0));
        check("rst_mid.busy", 64'(o.busy), 64'(0));
        check("rst_mid.packed", o.pk, 64'(0));
        check("rst_mid.unpacked", o.up, 64'(0));
        check("rst_mid.overflow", 64'(o.overflow), 64'(0));
        run_op(0, 7, 8, 3, "a7");
        check("a7.literal", 64'(a_pk), 64'h007);

        // Exhaustive 0..255 streaming with out_ready tied high
        drive(0, 1'b1, 0, 1'b1);
        nxt = 0;
        done_cnt = 0;
        ready_cycles = 0;
        cycles = 0;
        while (done_cnt < 256 && cycles < 4000) begin
            accept = a_in_ready && a_in_valid;
            if (a_in_ready) ready_cycles++;
            if (accept) exp_q.push_back(nxt);
            if (a_out_valid) begin
                if (exp_q.size() == 0) begin
                    check("exh.unexpected_result", 64'(a_out_valid), 64'(0));
                end else begin
                    model(longint'(exp_q.pop_front()), 3, ep, eu, eo);
                    check("exh.packed", 64'(a_pk), ep);
                    check("exh.overflow", 64'(a_ovf), 64'(eo));
                end
                done_cnt++;
            end
            tick();
            cycles++;
            if (accept) begin
                nxt++;
                drive(0, nxt < 256, longint'(nxt), 1'b1);
            end
        end
        drive(0, 1'b0, 0, 1'b0);
        check("exh.results", 64'(done_cnt), 64'(256));
        check("exh.cycles", 64'(cycles), 64'(2560));
        check("exh.ready_cycles", 64'(ready_cycles), 64'(256));
        tick();

        // Randomized operands on all three configurations
        for (int i = 0; i < 20; i++) begin
            run_op(0, longint'($urandom_range(0, 255)), 8, 3, "rand_a");
            run_op(1, longint'($urandom_range(0, 255)), 8, 2, "rand_b");
            run_op(2, longint'($urandom_range(0, 65535)), 16, 5, "rand_c");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
